reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
Parametrised register file with two read ports and one write port. Successor to the single-port, combinational enable-gated register read used by the datapath. Adds configurable width and depth, registered reads with valid flag, write-to-read bypass, and a hardware clear sequencer. Sits between decode (read addresses) and writeback (write port) in the CPU datapath.

Parameters:
DATA_W, 4, width of each register in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_en  in  1  read request for both read ports
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  read port 1 data, registered
rd_data2  out  DATA_W  read port 2 data, registered
rd_valid  out  1  rd_data1/rd_data2 hold a served read
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
clr_req  in  1  start clear-all sequence (single-cycle pulse or level)
busy  out  1  clear sequence in progress

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, immediate, independent of clk): all DEPTH entries = 0; rd_data1 = rd_data2 = 0; rd_valid = 0; busy = 0; FSM = IDLE; clear pointer = 0. Reset mid-clear aborts the sweep; result is identical to a completed clear.
- Read latency 1 cycle: rd_en=1 sampled at edge N -> at edge N+1 outputs valid: rd_dataK = mem[rd_addrK], rd_valid = 1.
- rd_en=0 at edge N -> rd_data1 = rd_data2 = 0, rd_valid = 0 after edge N (zero-gating, not hold).
- Write: wr_en=1 at edge N writes wr_data to mem[wr_addr]; visible to reads sampled from edge N onward.
- Bypass: rd_en and wr_en in the same cycle with rd_addrK == wr_addr -> rd_dataK = wr_data (new data), per port independently. Both ports may bypass simultaneously.
- FSM states IDLE, CLEAR.
  - IDLE: clr_req=1 -> CLEAR, pointer = 0. busy goes high after that edge.
  - CLEAR: each cycle writes 0 to mem[pointer], pointer++. Entry at pointer == DEPTH-1 -> write it, return to IDLE, busy low after that edge. busy is high for exactly DEPTH cycles.
- Priority in the IDLE cycle carrying clr_req: a concurrent wr_en is dropped; a concurrent rd_en is served normally with pre-clear data; no bypass from dropped write.
- During CLEAR (busy=1): wr_en ignored; rd_en ignored (rd_data = 0, rd_valid = 0); clr_req ignored (no restart).
- Pointer width ADDR_W; wraps naturally; no out-of-range addresses exist.
- No X on outputs after reset for any input sequence.

Optional Feature:
Macro R0_ZERO_EN. Defined: entry 0 is hardwired zero. Writes to address 0 are discarded, reads of address 0 return 0, and bypass never applies to address 0 (RISC-style zero register). Not defined: entry 0 is an ordinary register identical to all others.

Test Plan:
- Reset then rd_en=1, rd_addr1=3, rd_addr2=7 -> next cycle rd_data1=0, rd_data2=0, rd_valid=1.
- Write 4'hA to addr 5, next cycle rd_en=1 with rd_addr1=5, rd_addr2=5 -> one cycle later both outputs 4'hA, rd_valid=1. Then rd_en=0 -> outputs 0, rd_valid=0.
- Same cycle wr_en=1, wr_addr=2, wr_data=4'h6, rd_en=1, rd_addr1=2, rd_addr2=9 (mem[9]=4'h3) -> rd_data1=4'h6 (bypass), rd_data2=4'h3.
- Fill all 16 entries with nonzero data, pulse clr_req with concurrent wr_en to addr 1 -> busy high for 16 cycles, reads and writes during busy ignored, afterwards every address reads 0 (addr 1 write dropped).
- Assert rst_n=0 mid-clear at pointer=8, between clock edges -> outputs and busy go 0 immediately; after release all entries read 0 and FSM is IDLE.
- With R0_ZERO_EN defined: write 4'hF to addr 0 and read addr 0 in the same cycle, then again next cycle -> rd_data = 0 both times. Without the macro, the same stimulus gives 4'hF both times (bypass, then stored).

Source files
------------

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: read pair, write port and clear control.
// The master drives requests; the slave (the register file) returns data and status.
interface reg_file_2r1w_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) ();
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              rd_valid;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              clr_req;
   logic              busy;

   modport master (
      output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
      input  rd_data1, rd_data2, rd_valid, busy
   );

   modport slave (
      input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
      output rd_data1, rd_data2, rd_valid, busy
   );
endinterface

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with registered reads, write bypass and a clear sweeper.
// Define R0_ZERO_EN to hardwire entry 0 to zero (writes dropped, reads 0, no bypass).
module reg_file_2r1w #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   reg_file_2r1w_if.slave   bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_busy;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data1;
   logic [DATA_W-1:0] r_rd_data2;
   logic              r_rd_valid;

   logic              w_wr_ok;
   logic              w_rd_ok;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;

   // A write landing in the clr_req cycle is dropped, so it must not feed the bypass either.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_wr_ok = bus.wr_en && (r_state == S_IDLE) && !bus.clr_req;
      w_rd_ok = bus.rd_en && (r_state == S_IDLE);
`ifdef R0_ZERO_EN
      w_wr_ok = w_wr_ok && (bus.wr_addr != '0);
`endif
   end

   always_comb begin
      w_rd1 = r_mem[bus.rd_addr1];
      w_rd2 = r_mem[bus.rd_addr2];
      if (w_wr_ok && (bus.wr_addr == bus.rd_addr1)) w_rd1 = bus.wr_data;
      if (w_wr_ok && (bus.wr_addr == bus.rd_addr2)) w_rd2 = bus.wr_data;
`ifdef R0_ZERO_EN
      if (bus.rd_addr1 == '0) w_rd1 = '0;
      if (bus.rd_addr2 == '0) w_rd2 = '0;
`endif
   end

   // NOTE: the storage array sits under the async reset because a reset must leave every entry zero.
   // NOTE: sequential state uses non-blocking assignments only, so all reads see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_busy     <= 1'b0;
         r_rd_data1 <= '0;
         r_rd_data2 <= '0;
         r_rd_valid <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_rd_ok) begin
            r_rd_data1 <= w_rd1;
            r_rd_data2 <= w_rd2;
            r_rd_valid <= 1'b1;
         end else begin
            r_rd_data1 <= '0;
            r_rd_data2 <= '0;
            r_rd_valid <= 1'b0;
         end

         if (w_wr_ok) r_mem[bus.wr_addr] <= bus.wr_data;

         case (r_state)
            S_IDLE: begin
               if (bus.clr_req) begin
                  r_state <= S_CLEAR;
                  r_ptr   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_CLEAR: begin
               r_mem[r_ptr] <= '0;
               r_ptr        <= r_ptr + 1'b1;
               if (&r_ptr) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_data1 = r_rd_data1;
   assign bus.rd_data2 = r_rd_data2;
   assign bus.rd_valid = r_rd_valid;
   assign bus.busy     = r_busy;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: reads, bypass, clear sweep, reset mid-clear, entry 0.
// Expectations follow R0_ZERO_EN the same way the design does.
module tb_reg_file_2r1w;
   localparam int DATA_W = 4;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   reg_file_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      else             n_pass++;
   endtask

   // Inputs change 1 time unit after a rising edge and are sampled at the next one.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.rd_en = 1'b0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
      bus.wr_en = 1'b0; bus.wr_addr  = '0; bus.wr_data  = '0;
      bus.clr_req = 1'b0;
   endtask

   task automatic write(input logic [3:0] a, input logic [3:0] d);
      idle_inputs();
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      tick();
   endtask

   task automatic read(input logic [3:0] a1, input logic [3:0] a2);
      idle_inputs();
      bus.rd_en = 1'b1; bus.rd_addr1 = a1; bus.rd_addr2 = a2;
      tick();
   endtask

   initial begin
      int          busy_cycles;
      int          bad_during;
      logic [3:0]  r0_exp;

      n_checks = 0;
      n_pass   = 0;
      idle_inputs();
      rst_n = 1'b0;
      #23;
      check("rst_rd_data1", bus.rd_data1, 0);
      check("rst_rd_data2", bus.rd_data2, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_busy",     bus.busy,     0);
      tick();
      rst_n = 1'b1;

      read(4'd3, 4'd7);
      check("rd_after_rst_d1", bus.rd_data1, 0);
      check("rd_after_rst_d2", bus.rd_data2, 0);
      check("rd_after_rst_v",  bus.rd_valid, 1);

      write(4'd5, 4'hA);
      read(4'd5, 4'd5);
      check("rd5_d1", bus.rd_data1, 4'hA);
      check("rd5_d2", bus.rd_data2, 4'hA);
      check("rd5_v",  bus.rd_valid, 1);
      idle_inputs();
      tick();
      check("gate_d1", bus.rd_data1, 0);
      check("gate_d2", bus.rd_data2, 0);
      check("gate_v",  bus.rd_valid, 0);

      write(4'd9, 4'h3);
      idle_inputs();
      bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 4'h6;
      bus.rd_en = 1'b1; bus.rd_addr1 = 4'd2; bus.rd_addr2 = 4'd9;
      tick();
      check("byp_d1", bus.rd_data1, 4'h6);
      check("byp_d2", bus.rd_data2, 4'h3);
      read(4'd2, 4'd2);
      check("byp_stored", bus.rd_data1, 4'h6);

      idle_inputs();
      bus.wr_en = 1'b1; bus.wr_addr = 4'd6; bus.wr_data = 4'h8;
      bus.rd_en = 1'b1; bus.rd_addr1 = 4'd6; bus.rd_addr2 = 4'd6;
      tick();
      check("byp_both_d1", bus.rd_data1, 4'h8);
      check("byp_both_d2", bus.rd_data2, 4'h8);

      // Fill addr i with (i % 15) + 1, all nonzero.
      for (int i = 0; i < DEPTH; i++) write(4'(i), 4'((i % 15) + 1));
      read(4'd4, 4'd15);
      check("fill_d1", bus.rd_data1, 4'h5);
      check("fill_d2", bus.rd_data2, 4'h1);

      idle_inputs();
      bus.clr_req = 1'b1;
      bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 4'hC;
      bus.rd_en = 1'b1; bus.rd_addr1 = 4'd1; bus.rd_addr2 = 4'd4;
      tick();
      check("clr_pre_d1", bus.rd_data1, 4'h2);
      check("clr_pre_d2", bus.rd_data2, 4'h5);
      check("clr_pre_v",  bus.rd_valid, 1);
      check("clr_busy",   bus.busy,     1);

      busy_cycles = 1;
      bad_during  = 0;
      for (int n = 0; n < 40 && bus.busy; n++) begin
         idle_inputs();
         bus.rd_en = 1'b1; bus.rd_addr1 = 4'd7; bus.rd_addr2 = 4'd8;
         bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 4'h7;
         bus.clr_req = (n == 5);
         tick();
         if (bus.busy) begin
            busy_cycles++;
            if (bus.rd_valid !== 1'b0 || bus.rd_data1 !== '0 || bus.rd_data2 !== '0) bad_during++;
         end
      end
      check("busy_len",       busy_cycles, DEPTH);
      check("busy_rd_gated",  bad_during,  0);
      idle_inputs();
      tick();
      check("no_restart", bus.busy, 0);

      for (int i = 0; i < DEPTH; i++) begin
         read(4'(i), 4'(DEPTH - 1 - i));
         check($sformatf("cleared_a%0d", i),             bus.rd_data1, 0);
         check($sformatf("cleared_b%0d", DEPTH - 1 - i), bus.rd_data2, 0);
      end

      write(4'd10, 4'h9);
      write(4'd12, 4'h4);
      idle_inputs();
      bus.clr_req = 1'b1;
      tick();
      idle_inputs();
      for (int n = 0; n < 8; n++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("midclr_busy", bus.busy,     0);
      check("midclr_v",    bus.rd_valid, 0);
      check("midclr_d1",   bus.rd_data1, 0);
      #3;
      rst_n = 1'b1;
      tick();
      check("post_rst_idle", bus.busy, 0);
      read(4'd10, 4'd12);
      check("post_rst_a10", bus.rd_data1, 0);
      check("post_rst_a12", bus.rd_data2, 0);
      check("post_rst_v",   bus.rd_valid, 1);

`ifdef R0_ZERO_EN
      r0_exp = 4'h0;
`else
      r0_exp = 4'hF;
`endif
      idle_inputs();
      bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 4'hF;
      bus.rd_en = 1'b1; bus.rd_addr1 = 4'd0; bus.rd_addr2 = 4'd0;
      tick();
      check("r0_byp_d1", bus.rd_data1, r0_exp);
      check("r0_byp_d2", bus.rd_data2, r0_exp);
      read(4'd0, 4'd5);
      check("r0_stored", bus.rd_data1, r0_exp);
      check("r0_other",  bus.rd_data2, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
